// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: widths, field
// positions inside the 20-bit instruction word, opcodes and FSM states.
package isa_pkg;

  localparam int IW   = 9;
  localparam int DW   = 20;
  localparam int OFFW = 15;

  // Field slice positions inside the instruction word
  localparam int OPC_HI = 19;
  localparam int OPC_LO = 15;
  localparam int FA_HI  = 14;
  localparam int FA_LO  = 10;
  localparam int FB_HI  = 9;
  localparam int FB_LO  = 5;
  localparam int FC_HI  = 4;
  localparam int FC_LO  = 0;
  localparam int OFF_HI = 14;
  localparam int OFF_LO = 0;

  // Bit positions inside the {eq,lt,gt} flag register
  localparam int FLAG_EQ = 2;
  localparam int FLAG_LT = 1;
  localparam int FLAG_GT = 0;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_XOR  = 5'd2,
    OP_AND  = 5'd3,
    OP_SLL  = 5'd4,
    OP_SRL  = 5'd5,
    OP_CMP  = 5'd6,
    OP_BE   = 5'd7,
    OP_BL   = 5'd8,
    OP_BG   = 5'd9,
    OP_BA   = 5'd10,
    OP_MOV  = 5'd11,
    OP_LD   = 5'd12,
    OP_ST   = 5'd13,
    OP_DONE = 5'd14
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MEMW = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/branch_unit.sv
// Branch resolution: decides whether the current opcode is a taken branch
// given the flag register, and forms the target iptr + sext(offset) mod 2^IW.
module branch_unit
  import isa_pkg::*;
(
  input  logic [4:0]      opcode,
  input  logic [2:0]      flags,
  input  logic [IW-1:0]   iptr,
  input  logic [OFFW-1:0] offset,
  output logic            taken,
  output logic [IW-1:0]   target
);

  logic [OFFW-1:0] sum;

  // Taken decision per branch flavour; ba is unconditional
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BE:   taken = flags[FLAG_EQ];
      OP_BL:   taken = flags[FLAG_LT];
      OP_BG:   taken = flags[FLAG_GT];
      OP_BA:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Add at offset width, then keep the low IW bits so the target wraps mod 512
  always_comb begin
    sum    = OFFW'(iptr) + offset;
    target = sum[IW-1:0];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/control sequencer between the instruction ROM and the datapath.
// Optional macro INSTR_COUNT_EN adds a saturating 16-bit retired-instruction
// counter on output `retired`, cleared on reset and on an accepted Start.
module instr_sequencer
  import isa_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  input  logic [DW-1:0] inst,
  input  logic          cmp_eq,
  input  logic          cmp_lt,
  input  logic          cmp_gt,
  input  logic          mem_ack,
  output logic [IW-1:0] iptr,
  output logic [4:0]    opcode,
  output logic [4:0]    fld_a,
  output logic [4:0]    fld_b,
  output logic [4:0]    fld_c,
  output logic          reg_we,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          busy,
  output logic          Done
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]   retired
`endif
);

  state_t        state_q, state_d;
  logic [IW-1:0] iptr_q, iptr_d;
  logic [2:0]    flags_q, flags_d;
  logic          mem_ld_q, mem_ld_d;

  logic [4:0]    opc;
  logic [IW-1:0] iptr_inc;
  logic          br_taken;
  logic [IW-1:0] br_target;

  assign opc      = inst[OPC_HI:OPC_LO];
  assign opcode   = opc;
  assign fld_a    = inst[FA_HI:FA_LO];
  assign fld_b    = inst[FB_HI:FB_LO];
  assign fld_c    = inst[FC_HI:FC_LO];
  assign iptr     = iptr_q;
  assign iptr_inc = iptr_q + IW'(1);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_MEMW);
  assign Done     = (state_q == ST_HALT);

  branch_unit u_branch (
    .opcode (opc),
    .flags  (flags_q),
    .iptr   (iptr_q),
    .offset (inst[OFF_HI:OFF_LO]),
    .taken  (br_taken),
    .target (br_target)
  );

  // Next-state, pointer, flag and control-strobe decode for one instruction per cycle
  always_comb begin
    state_d  = state_q;
    iptr_d   = iptr_q;
    flags_d  = flags_q;
    mem_ld_d = mem_ld_q;
    reg_we   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_d = ST_RUN;
          iptr_d  = StartAddr;
        end
      end
      ST_RUN: begin
        case (opc)
          OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_SLL, OP_SRL, OP_MOV: begin
            reg_we = 1'b1;
            iptr_d = iptr_inc;
          end
          OP_CMP: begin
            flags_d = {cmp_eq, cmp_lt, cmp_gt};
            iptr_d  = iptr_inc;
          end
          OP_BE, OP_BL, OP_BG, OP_BA: begin
            iptr_d = br_taken ? br_target : iptr_inc;
          end
          OP_LD, OP_ST: begin
            mem_rd = (opc == OP_LD);
            mem_wr = (opc == OP_ST);
            if (mem_ack) begin
              reg_we = (opc == OP_LD);
              iptr_d = iptr_inc;
            end else begin
              state_d  = ST_MEMW;
              mem_ld_d = (opc == OP_LD);
            end
          end
          default: begin
            state_d = ST_HALT;
          end
        endcase
      end
      ST_MEMW: begin
        mem_rd = mem_ld_q;
        mem_wr = !mem_ld_q;
        if (mem_ack) begin
          reg_we  = mem_ld_q;
          iptr_d  = iptr_inc;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers; async reset returns to IDLE and drops any request
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      iptr_q   <= '0;
      flags_q  <= '0;
      mem_ld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      iptr_q   <= iptr_d;
      flags_q  <= flags_d;
      mem_ld_q <= mem_ld_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic        start_acc;
  logic        retire;
  logic [15:0] retired_q, retired_d;

  // An instruction retires when it completes: any RUN op except a memory op still waiting, or an acked MEMW
  always_comb begin
    start_acc = ((state_q == ST_IDLE) || (state_q == ST_HALT)) && Start;
    retire    = 1'b0;
    if (state_q == ST_RUN) begin
      retire = !(((opc == OP_LD) || (opc == OP_ST)) && !mem_ack);
    end else if (state_q == ST_MEMW) begin
      retire = mem_ack;
    end
    retired_d = retired_q;
    if (start_acc) begin
      retired_d = '0;
    end else if (retire && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  // Saturating retired-instruction counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer. Inputs are driven 1 time
// unit after each rising edge; outputs are checked in that same settled window.
// Also exercises the `retired` counter when INSTR_COUNT_EN is defined.
module tb_instr_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [8:0]  StartAddr;
  logic [19:0] inst;
  logic        cmp_eq, cmp_lt, cmp_gt;
  logic        mem_ack;
  logic [8:0]  iptr;
  logic [4:0]  opcode, fld_a, fld_b, fld_c;
  logic        reg_we, mem_rd, mem_wr, busy, Done;
`ifdef INSTR_COUNT_EN
  logic [15:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  instr_sequencer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .StartAddr (StartAddr),
    .inst      (inst),
    .cmp_eq    (cmp_eq),
    .cmp_lt    (cmp_lt),
    .cmp_gt    (cmp_gt),
    .mem_ack   (mem_ack),
    .iptr      (iptr),
    .opcode    (opcode),
    .fld_a     (fld_a),
    .fld_b     (fld_b),
    .fld_c     (fld_c),
    .reg_we    (reg_we),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .Done      (Done)
`ifdef INSTR_COUNT_EN
    ,
    .retired   (retired)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [14:0] off);
    return {op, off};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [19:0] i, input logic st, input logic [8:0] sa,
                               input logic eq, input logic lt, input logic gt, input logic ack);
    inst      = i;
    Start     = st;
    StartAddr = sa;
    cmp_eq    = eq;
    cmp_lt    = lt;
    cmp_gt    = gt;
    mem_ack   = ack;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    applyStimulus(20'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #2 Reset_n = 1'b1;
    #1;
    checkOutput("rst_iptr", 16'(iptr), 16'h000);
    checkOutput("rst_done", 16'(Done), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_mem_rd", 16'(mem_rd), 16'h0);
    tick();
    checkOutput("idle_iptr_held", 16'(iptr), 16'h000);

    // Start at 1 running adds
    applyStimulus(mk(5'd0, 15'h1234), 1'b1, 9'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_reg_we", 16'(reg_we), 16'h0);
    tick();
    applyStimulus(mk(5'd0, 15'h1234), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start_iptr", 16'(iptr), 16'h001);
    checkOutput("start_busy", 16'(busy), 16'h1);
    checkOutput("add_reg_we1", 16'(reg_we), 16'h1);
    checkOutput("fld_a", 16'(fld_a), 16'h04);
    checkOutput("fld_c", 16'(fld_c), 16'h14);
    tick();
    checkOutput("add_iptr2", 16'(iptr), 16'h002);
    checkOutput("add_reg_we2", 16'(reg_we), 16'h1);
    tick();
    checkOutput("add_iptr3", 16'(iptr), 16'h003);

    // Backward branch, taken then not taken
    applyStimulus(mk(5'd6, 15'd0), 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("cmp_reg_we", 16'(reg_we), 16'h0);
    tick();
    checkOutput("cmp_iptr", 16'(iptr), 16'h004);
    applyStimulus(mk(5'd10, 15'd12), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ba_fwd_iptr", 16'(iptr), 16'h010);
    applyStimulus(20'b01000_11111_11111_10011, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bl_reg_we", 16'(reg_we), 16'h0);
    tick();
    checkOutput("bl_taken_iptr", 16'(iptr), 16'h003);
    applyStimulus(mk(5'd6, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(mk(5'd10, 15'd12), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(20'b01000_11111_11111_10011, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bl_not_taken_iptr", 16'(iptr), 16'h011);

    // Forward branch on eq
    applyStimulus(mk(5'd6, 15'd0), 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(mk(5'd10, 15'h7FF3), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ba_back_iptr", 16'(iptr), 16'h005);
    applyStimulus(mk(5'd7, 15'd4), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("be_taken_iptr", 16'(iptr), 16'h009);
    applyStimulus(mk(5'd9, 15'd4), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bg_not_taken_iptr", 16'(iptr), 16'h00A);
    applyStimulus(mk(5'd10, 15'h7FF7), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ba_to_ld_iptr", 16'(iptr), 16'h001);

    // Load with three wait cycles
    applyStimulus(mk(5'd12, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_c1_mem_rd", 16'(mem_rd), 16'h1);
    checkOutput("ld_c1_reg_we", 16'(reg_we), 16'h0);
    tick();
    checkOutput("ld_c2_mem_rd", 16'(mem_rd), 16'h1);
    checkOutput("ld_c2_iptr", 16'(iptr), 16'h001);
    checkOutput("ld_c2_busy", 16'(busy), 16'h1);
    tick();
    checkOutput("ld_c3_mem_rd", 16'(mem_rd), 16'h1);
    checkOutput("ld_c3_reg_we", 16'(reg_we), 16'h0);
    applyStimulus(mk(5'd12, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(mk(5'd12, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ld_c4_mem_rd", 16'(mem_rd), 16'h1);
    checkOutput("ld_c4_reg_we", 16'(reg_we), 16'h1);
    checkOutput("ld_c4_iptr", 16'(iptr), 16'h001);
    tick();
    checkOutput("ld_done_iptr", 16'(iptr), 16'h002);

    // Load acknowledged in the issue cycle
    applyStimulus(mk(5'd12, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ld0_mem_rd", 16'(mem_rd), 16'h1);
    checkOutput("ld0_reg_we", 16'(reg_we), 16'h1);
    tick();
    checkOutput("ld0_iptr", 16'(iptr), 16'h003);
    checkOutput("ld0_busy", 16'(busy), 16'h1);

    // Store waiting, then async reset mid-MEMW
    applyStimulus(mk(5'd13, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("st_mem_wr", 16'(mem_wr), 16'h1);
    checkOutput("st_reg_we", 16'(reg_we), 16'h0);
    tick();
    checkOutput("st_memw_mem_wr", 16'(mem_wr), 16'h1);
    checkOutput("st_memw_mem_rd", 16'(mem_rd), 16'h0);
    checkOutput("st_memw_iptr", 16'(iptr), 16'h003);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("async_rst_mem_wr", 16'(mem_wr), 16'h0);
    checkOutput("async_rst_iptr", 16'(iptr), 16'h000);
    checkOutput("async_rst_busy", 16'(busy), 16'h0);
    checkOutput("async_rst_done", 16'(Done), 16'h0);
    tick();
    #2 Reset_n = 1'b1;
`ifdef INSTR_COUNT_EN
    checkOutput("rst_retired", retired, 16'd0);
`endif
    tick();

    // Run to done, ignore Start while busy, restart from HALT
    applyStimulus(mk(5'd0, 15'd0), 1'b1, 9'h017, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("start17_iptr", 16'(iptr), 16'h017);
    applyStimulus(mk(5'd0, 15'd0), 1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ignored_start_iptr", 16'(iptr), 16'h018);
    checkOutput("ignored_start_busy", 16'(busy), 16'h1);
    applyStimulus(mk(5'd14, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_reg_we", 16'(reg_we), 16'h0);
    checkOutput("done_pre_Done", 16'(Done), 16'h0);
    tick();
    checkOutput("halt_Done", 16'(Done), 16'h1);
    checkOutput("halt_iptr", 16'(iptr), 16'h018);
    checkOutput("halt_busy", 16'(busy), 16'h0);
    tick();
    checkOutput("halt_hold_iptr", 16'(iptr), 16'h018);
    checkOutput("halt_hold_Done", 16'(Done), 16'h1);
`ifdef INSTR_COUNT_EN
    checkOutput("halt_retired", retired, 16'd2);
`endif
    applyStimulus(mk(5'd14, 15'd0), 1'b1, 9'h019, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("restart_iptr", 16'(iptr), 16'h019);
    checkOutput("restart_Done", 16'(Done), 16'h0);
    checkOutput("restart_busy", 16'(busy), 16'h1);
`ifdef INSTR_COUNT_EN
    checkOutput("restart_retired", retired, 16'd0);
`endif

    // Pointer increment wraps 511 -> 0
    applyStimulus(mk(5'd10, 15'h01E6), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ba_to_1ff_iptr", 16'(iptr), 16'h1FF);
    applyStimulus(mk(5'd11, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mov_reg_we", 16'(reg_we), 16'h1);
    tick();
    checkOutput("wrap_iptr", 16'(iptr), 16'h000);
`ifdef INSTR_COUNT_EN
    checkOutput("wrap_retired", retired, 16'd2);
`endif

    // Illegal opcode halts like done
    applyStimulus(mk(5'd20, 15'd0), 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("illegal_Done", 16'(Done), 16'h1);
    checkOutput("illegal_iptr", 16'(iptr), 16'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch and control sequencer that sits on the other end of the instruction ROM interface.
- Drives the 9-bit instruction pointer and consumes the 20-bit instruction the ROM returns combinationally.
- Decodes opcode and fields, resolves branches against a local flag register, and stalls on load/store handshakes.
- Runs one program from a Start pulse until the `done` opcode executes; sits between the ROM and the datapath/data-memory.

Parameters:
- IW, 9, instruction pointer width
- DW, 20, instruction width
- OFFW, 15, branch offset width (inst[14:0], two's complement)

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; begin execution at StartAddr
- StartAddr  in  9  program entry pointer
- inst  in  20  instruction from ROM for current iptr
- cmp_eq / cmp_lt / cmp_gt  in  1 each  datapath comparison of operand A vs B this cycle
- mem_ack  in  1  data memory completed current ld/st
- iptr  out  9  instruction pointer to ROM
- opcode  out  5  inst[19:15]
- fld_a / fld_b / fld_c  out  5 each  inst[14:10], [9:5], [4:0]
- reg_we  out  1  write register fld_a this cycle
- mem_rd / mem_wr  out  1 each  load/store request, held until mem_ack
- busy  out  1  state RUN or MEMW
- Done  out  1  high in HALT

Behaviour:
- Reset (async): state=IDLE, iptr=0, flags={eq,lt,gt}=0, all control outputs 0, Done=0. Decoded field outputs are a function of inst and need no reset.
- Opcodes:
  - 0 add, 1 sub, 2 xor, 3 and, 4 sll, 5 srl: ALU ops
  - 6 cmp; 7 be, 8 bl, 9 bg, 10 ba: branches
  - 11 mov, 12 ld, 13 st, 14 done
  - 15–31: illegal
- States:
  - IDLE: iptr held. Start → RUN with iptr<=StartAddr.
  - RUN: one instruction per cycle.
    - ALU ops and mov: reg_we=1, iptr+1.
    - cmp: flags<={cmp_eq,cmp_lt,cmp_gt}, reg_we=0, iptr+1.
    - be/bl/bg: branch if eq/lt/gt respectively; ba always. Taken: iptr<=iptr+sext(inst[14:0]), truncated mod 512. Not taken: iptr+1. Branches never write flags or registers.
    - ld/st: mem_rd or mem_wr=1, go MEMW; iptr held.
    - done: → HALT; iptr held.
    - illegal: treated as done.
  - MEMW: mem_rd/mem_wr stays asserted and iptr is held until mem_ack. When mem_ack arrives:
    - ld asserts reg_we for that same cycle;
    - the request drops, iptr+1, → RUN.
    - mem_ack with zero wait (same cycle as issue) is also legal and completes in that RUN cycle with no MEMW visit.
  - HALT: Done=1. Start → RUN at StartAddr with Done deasserting the same edge; otherwise stay.
- Start while busy is ignored.
- Pointer increment wraps 511→0.
- Flags persist across programs and are cleared only by reset.
- Reset mid-MEMW drops the request immediately (async).
- Latency: Start to first instruction at iptr is 1 cycle. Each non-memory instruction takes 1 cycle; ld/st take 1 + wait cycles.

Optional Feature:
- INSTR_COUNT_EN defined:
  - adds output `retired` [15:0], which increments on each completed instruction (including done) and saturates at 16'hFFFF;
  - cleared on Start and on reset.
- Undefined: the port and counter are absent.

Decomposition:
- Package `isa_pkg` holds:
  - the opcode enum (5-bit, values above);
  - the state enum {IDLE, RUN, MEMW, HALT};
  - field slice constants;
  - IW/DW/OFFW.
- One sub-module `branch_unit`: combinational taken decision plus target adder, given opcode, flags, iptr and offset.

Test Plan:
- Reset: Reset_n low async mid-cycle → iptr=0, Done=0, busy=0, mem_rd/mem_wr=0 immediately.
- Start: Start with StartAddr=1; inst=add (opcode 0) → iptr 1,2,3 on successive cycles, reg_we=1 each.
- Backward branch: cmp with cmp_lt=1, then inst 20'b01000_11111_11111_10011 at iptr=0x10 → iptr=0x03. With cmp_lt=0 → iptr=0x11.
- Forward branch: be offset +4 at iptr=5 with eq flag set → iptr=9.
- Load wait: ld at iptr=1, mem_ack after 3 cycles → mem_rd high 4 cycles, iptr held at 1, reg_we pulse on ack cycle, then iptr=2. Repeat with same-cycle ack → completes in 1 cycle.
- Done and ignored Start:
  - done at iptr=0x18 → Done=1, iptr stays 0x18;
  - Start pulse during RUN is ignored;
  - Start in HALT with StartAddr=0x19 → iptr=0x19, Done=0 next cycle;
  - with INSTR_COUNT_EN, `retired` restarts at 0.
